// File: rtl/node.sv
// node: host <-> router endpoint with a 5-packet outbound queue (4-entry FIFO + head register)
// and 4-byte serial framing on both links. Define NODE_PROTOCOL_CHECK_EN for simulation protocol checks.
module node #(
  parameter logic [3:0] NODEID = 4'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_avail,
  output logic        cQ_full,
  output logic [31:0] pkt_out,
  output logic        pkt_out_avail,
  output logic        free_inbound,
  input  logic        put_inbound,
  input  logic [7:0]  payload_inbound,
  input  logic        free_outbound,
  output logic        put_outbound,
  output logic [7:0]  payload_outbound,
  output logic [2:0]  dbg_send_state,
  output logic [2:0]  dbg_recv_state,
  output logic [3:0]  dbg_node_id
);

  // Handshake: a host strobe counts only while cQ_full is low; a link transfer is put=1 for
  // four consecutive cycles, started only when the receiver's free signal was high.
  typedef enum logic [2:0] {S_IDLE, S_SEND0, S_SEND1, S_SEND2, S_SEND3} send_state_e;
  typedef enum logic [2:0] {R_IDLE, R_RECV1, R_RECV2, R_RECV3, R_DELIVER} recv_state_e;

  send_state_e send_state_q, send_state_d;
  recv_state_e recv_state_q, recv_state_d;

  logic [31:0] fifo_mem_q [4];
  logic [31:0] fifo_mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  fifo_cnt_q, fifo_cnt_d;
  logic [31:0] head_q, head_d;
  logic        head_valid_q, head_valid_d;
  logic        cq_full_q, cq_full_d;
  logic [23:0] rx_buf_q, rx_buf_d;
  logic [31:0] pkt_out_q, pkt_out_d;
  logic        enq, deq, push, pop;

  // ---------------- send FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) send_state_q <= S_IDLE;
    else          send_state_q <= send_state_d;
  end

  always_comb begin
    send_state_d = send_state_q;
    case (send_state_q)
      S_IDLE:  if (head_valid_q && free_outbound) send_state_d = S_SEND0;
      S_SEND0: send_state_d = S_SEND1;
      S_SEND1: send_state_d = S_SEND2;
      S_SEND2: send_state_d = S_SEND3;
      S_SEND3: send_state_d = S_IDLE;
      default: send_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    put_outbound     = 1'b0;
    payload_outbound = 8'h00;
    case (send_state_q)
      S_SEND0: begin put_outbound = 1'b1; payload_outbound = head_q[31:24]; end
      S_SEND1: begin put_outbound = 1'b1; payload_outbound = head_q[23:16]; end
      S_SEND2: begin put_outbound = 1'b1; payload_outbound = head_q[15:8];  end
      S_SEND3: begin put_outbound = 1'b1; payload_outbound = head_q[7:0];   end
      default: begin put_outbound = 1'b0; payload_outbound = 8'h00;         end
    endcase
  end

  // ---------------- outbound queue ----------------
  // The head is refilled on the same edge it is released, so a waiting packet can start
  // right after the single IDLE cycle that follows SEND3.
  always_comb begin
    fifo_mem_d   = fifo_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    enq          = pkt_in_avail && !cq_full_q;
    deq          = (send_state_q == S_SEND3);
    push         = 1'b0;
    pop          = 1'b0;
    if (!head_valid_q || deq) begin
      if (fifo_cnt_q != 3'd0) begin
        head_d       = fifo_mem_q[rd_ptr_q];
        head_valid_d = 1'b1;
        pop          = 1'b1;
        push         = enq;
      end else if (enq) begin
        head_d       = pkt_in;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else begin
      push = enq;
    end
    if (push) begin
      fifo_mem_d[wr_ptr_q] = pkt_in;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};
    cq_full_d  = head_valid_d && (fifo_cnt_d == 3'd4);
  end

  // ---------------- receive FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) recv_state_q <= R_IDLE;
    else          recv_state_q <= recv_state_d;
  end

  always_comb begin
    recv_state_d = recv_state_q;
    rx_buf_d     = rx_buf_q;
    pkt_out_d    = pkt_out_q;
    case (recv_state_q)
      R_IDLE: begin
        if (put_inbound) begin
          rx_buf_d     = {rx_buf_q[15:0], payload_inbound};
          recv_state_d = R_RECV1;
        end
      end
      R_RECV1: begin
        rx_buf_d     = {rx_buf_q[15:0], payload_inbound};
        recv_state_d = R_RECV2;
      end
      R_RECV2: begin
        rx_buf_d     = {rx_buf_q[15:0], payload_inbound};
        recv_state_d = R_RECV3;
      end
      R_RECV3: begin
        pkt_out_d    = {rx_buf_q, payload_inbound};
        recv_state_d = R_DELIVER;
      end
      R_DELIVER: recv_state_d = R_IDLE;
      default:   recv_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    free_inbound  = (recv_state_q == R_IDLE);
    pkt_out_avail = (recv_state_q == R_DELIVER);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      cq_full_q    <= 1'b0;
      rx_buf_q     <= '0;
      pkt_out_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      cq_full_q    <= cq_full_d;
      rx_buf_q     <= rx_buf_d;
      pkt_out_q    <= pkt_out_d;
    end
  end

  always_ff @(posedge clock) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign cQ_full        = cq_full_q;
  assign pkt_out        = pkt_out_q;
  assign dbg_send_state = send_state_q;
  assign dbg_recv_state = recv_state_q;
  assign dbg_node_id    = NODEID;

`ifdef NODE_PROTOCOL_CHECK_EN
  // The router legitimately holds put_inbound through RECV1..RECV3, so only a put during
  // DELIVER is an attempt to start a packet while the node is not free.
  host_overrun_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(pkt_in_avail && cq_full_q))
    else $error("node %0d: pkt_in_avail while cQ_full", NODEID);
  router_overrun_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(put_inbound && recv_state_q == R_DELIVER))
    else $error("node %0d: put_inbound while free_inbound low", NODEID);
`endif

endmodule

// File: tb/tb_node.sv
// tb_node: drives host and router sides of node, checks against a packet-level model.
module tb_node;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pkt_in = '0;
  logic        pkt_in_avail = 1'b0;
  logic        put_inbound = 1'b0;
  logic [7:0]  payload_inbound = '0;
  logic        free_outbound = 1'b0;
  logic        cQ_full, pkt_out_avail, free_inbound, put_outbound;
  logic [31:0] pkt_out;
  logic [7:0]  payload_outbound;
  logic [2:0]  dbg_send_state, dbg_recv_state;
  logic [3:0]  dbg_node_id;

  node #(.NODEID(4'd3)) dut (
    .clock(clock), .reset_n(reset_n), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
    .cQ_full(cQ_full), .pkt_out(pkt_out), .pkt_out_avail(pkt_out_avail),
    .free_inbound(free_inbound), .put_inbound(put_inbound), .payload_inbound(payload_inbound),
    .free_outbound(free_outbound), .put_outbound(put_outbound), .payload_outbound(payload_outbound),
    .dbg_send_state(dbg_send_state), .dbg_recv_state(dbg_recv_state), .dbg_node_id(dbg_node_id)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: packets held in the queue, expected/observed packet streams
  logic [31:0] exp_q[$];
  logic [31:0] obs_out_q[$];
  logic [31:0] exp_in_q[$];
  logic [31:0] obs_in_q[$];
  int          held = 0;
  int          nbytes = 0;
  int          rx_cnt = 0;
  logic [31:0] part = '0;
  logic [23:0] rx_acc = '0;
  logic [31:0] last_out = '0;
  bit          rst_prev = 1'b0;
  int          full_err = 0, free_err = 0, run_err = 0, idle_err = 0, hold_err = 0;

  // One clock cycle: observe outputs at the falling edge, update the model, drive next inputs.
  task automatic tick(input bit r, input bit av, input logic [31:0] p,
                      input bit fo, input bit pi, input logic [7:0] pb);
    bit full_now;
    @(negedge clock);
    if (!rst_prev) begin
      held = 0; nbytes = 0; rx_cnt = 0; last_out = '0;
      exp_q.delete();
    end
    full_now = (held == 5);
    if (cQ_full !== full_now) full_err++;
    if (free_inbound !== (rx_cnt == 0)) free_err++;
    if (put_outbound === 1'b1) begin
      part = {part[23:0], payload_outbound};
      nbytes++;
      if (nbytes == 4) begin
        obs_out_q.push_back(part);
        held--;
        nbytes = 0;
      end
    end else begin
      if (nbytes != 0) run_err++;
      nbytes = 0;
      if (payload_outbound !== 8'h00) idle_err++;
    end
    if (pkt_out_avail === 1'b1) begin
      obs_in_q.push_back(pkt_out);
      last_out = pkt_out;
    end else if (pkt_out !== last_out) begin
      hold_err++;
    end
    reset_n = r; pkt_in_avail = av; pkt_in = p;
    free_outbound = fo; put_inbound = pi; payload_inbound = pb;
    if (r) begin
      if (av && !full_now) begin
        exp_q.push_back(p);
        held++;
      end
      if (rx_cnt == 0) begin
        if (pi) begin
          rx_cnt = 4;
          rx_acc = {16'h0000, pb};
        end
      end else begin
        if (rx_cnt == 2) exp_in_q.push_back({rx_acc, pb});
        else if (rx_cnt > 2) rx_acc = {rx_acc[15:0], pb};
        rx_cnt--;
      end
    end
    rst_prev = r;
  endtask

  task automatic test_reset();
    tick(0, 0, '0, 0, 0, 8'h00);
    tick(0, 1, 32'hFFFF_FFFF, 1, 1, 8'hFF);
    tick(1, 0, '0, 0, 0, 8'h00);
    n_checks++; if (cQ_full !== 1'b0) $display("FAIL reset_cq_full: got %b want 0", cQ_full); else n_pass++;
    n_checks++; if (free_inbound !== 1'b1) $display("FAIL reset_free_inbound: got %b want 1", free_inbound); else n_pass++;
    n_checks++; if (put_outbound !== 1'b0) $display("FAIL reset_put_outbound: got %b want 0", put_outbound); else n_pass++;
    n_checks++; if (payload_outbound !== 8'h00) $display("FAIL reset_payload_outbound: got %h want 00", payload_outbound); else n_pass++;
    n_checks++; if (pkt_out !== 32'h0) $display("FAIL reset_pkt_out: got %h want 00000000", pkt_out); else n_pass++;
    n_checks++; if (pkt_out_avail !== 1'b0) $display("FAIL reset_pkt_out_avail: got %b want 0", pkt_out_avail); else n_pass++;
  endtask

  task automatic test_single_send();
    int waited;
    logic [31:0] got, want;
    tick(1, 1, 32'h1234_5678, 1, 0, 8'h00);
    waited = 0;
    while (obs_out_q.size() == 0 && waited < 12) begin
      tick(1, 0, '0, 1, 0, 8'h00);
      waited++;
    end
    n_checks++; if (waited > 6) $display("FAIL send_latency: got %0d cycles want <= 6", waited); else n_pass++;
    n_checks++;
    if (obs_out_q.size() == 0 || exp_q.size() == 0) begin
      $display("FAIL send_single: got %0d packets want 1", obs_out_q.size());
    end else begin
      got = obs_out_q.pop_front(); want = exp_q.pop_front();
      if (got !== want || got !== 32'h1234_5678) $display("FAIL send_single: got %h want %h", got, want);
      else n_pass++;
    end
    repeat (3) tick(1, 0, '0, 1, 0, 8'h00);
    n_checks++; if (run_err !== 0) $display("FAIL send_run_length: got %0d short runs want 0", run_err); else n_pass++;
  endtask

  task automatic test_queue_full();
    logic [31:0] pk [5];
    logic [31:0] got, want;
    int waited;
    pk[0] = 32'h1234_5678; pk[1] = 32'h9ABC_DEF0; pk[2] = 32'h0FED_CBA9;
    pk[3] = 32'h8765_4321; pk[4] = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) tick(1, 1, pk[i], 0, 0, 8'h00);
    tick(1, 0, '0, 0, 0, 8'h00);
    n_checks++; if (cQ_full !== 1'b1) $display("FAIL full_after_five: got %b want 1", cQ_full); else n_pass++;
    tick(1, 1, 32'h1111_1111, 0, 0, 8'h00);
    tick(1, 0, '0, 0, 0, 8'h00);
    n_checks++; if (obs_out_q.size() !== 0) $display("FAIL hold_while_not_free: got %0d packets want 0", obs_out_q.size()); else n_pass++;
    tick(1, 0, '0, 1, 0, 8'h00);
    waited = 0;
    while (obs_out_q.size() == 0 && waited < 10) begin
      tick(1, 0, '0, 0, 0, 8'h00);
      waited++;
    end
    n_checks++;
    if (obs_out_q.size() == 0 || exp_q.size() == 0) begin
      $display("FAIL drain_one: got %0d packets want 1", obs_out_q.size());
    end else begin
      got = obs_out_q.pop_front(); want = exp_q.pop_front();
      if (got !== want || got !== pk[0]) $display("FAIL drain_one: got %h want %h", got, want);
      else n_pass++;
    end
    tick(1, 0, '0, 0, 0, 8'h00);
    n_checks++; if (cQ_full !== 1'b0) $display("FAIL full_clear_after_drain: got %b want 0", cQ_full); else n_pass++;
    tick(1, 1, 32'hDEAD_BEEF, 0, 0, 8'h00);
    tick(1, 0, '0, 0, 0, 8'h00);
    n_checks++; if (cQ_full !== 1'b1) $display("FAIL full_after_refill: got %b want 1", cQ_full); else n_pass++;
  endtask

  task automatic test_drain();
    logic [31:0] order [5];
    logic [31:0] got, want;
    int waited;
    order[0] = 32'h9ABC_DEF0; order[1] = 32'h0FED_CBA9; order[2] = 32'h8765_4321;
    order[3] = 32'hCAFE_F00D; order[4] = 32'hDEAD_BEEF;
    waited = 0;
    while (obs_out_q.size() < 5 && waited < 50) begin
      tick(1, 0, '0, 1, 0, 8'h00);
      waited++;
    end
    n_checks++; if (obs_out_q.size() !== 5) $display("FAIL drain_count: got %0d want 5", obs_out_q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs_out_q.size() == 0 || exp_q.size() == 0) begin
        $display("FAIL drain_order[%0d]: got none want %h", i, order[i]);
      end else begin
        got = obs_out_q.pop_front(); want = exp_q.pop_front();
        if (got !== want || got !== order[i]) $display("FAIL drain_order[%0d]: got %h want %h", i, got, order[i]);
        else n_pass++;
      end
    end
    tick(1, 0, '0, 1, 0, 8'h00);
    n_checks++; if (cQ_full !== 1'b0) $display("FAIL drain_cq_full: got %b want 0", cQ_full); else n_pass++;
  endtask

  task automatic test_receive();
    logic [7:0] b [4];
    logic [31:0] got, want;
    int k, deliv;
    b[0] = 8'h05; b[1] = 8'hEA; b[2] = 8'hF0; b[3] = 8'h0D;
    deliv = -1;
    for (k = 0; k < 10; k++) begin
      if (k < 4) tick(1, 0, '0, 0, 1, b[k]);
      else       tick(1, 0, '0, 0, 0, 8'h00);
      if (deliv < 0 && obs_in_q.size() != 0) deliv = k;
    end
    n_checks++; if (deliv < 0 || deliv > 5) $display("FAIL recv_latency: got %0d want 1..5", deliv); else n_pass++;
    n_checks++; if (obs_in_q.size() !== 1) $display("FAIL recv_pulse_count: got %0d want 1", obs_in_q.size()); else n_pass++;
    n_checks++;
    if (obs_in_q.size() == 0 || exp_in_q.size() == 0) begin
      $display("FAIL recv_packet: got none want 05eaf00d");
    end else begin
      got = obs_in_q.pop_front(); want = exp_in_q.pop_front();
      if (got !== want || got !== 32'h05EA_F00D) $display("FAIL recv_packet: got %h want %h", got, want);
      else n_pass++;
    end
    n_checks++; if (pkt_out !== 32'h05EA_F00D) $display("FAIL recv_hold: got %h want 05eaf00d", pkt_out); else n_pass++;
  endtask

  task automatic test_concurrent();
    logic [7:0] b [4];
    logic [31:0] got, want;
    int deliv;
    b[0] = 8'h01; b[1] = 8'h02; b[2] = 8'h03; b[3] = 8'h04;
    deliv = -1;
    for (int k = 0; k < 25; k++) begin
      if (k == 0)      tick(1, 1, 32'h5161_7181, 1, 1, b[0]);
      else if (k == 1) tick(1, 1, 32'hF2F3_F4F5, 1, 1, b[1]);
      else if (k < 4)  tick(1, 0, '0, 1, 1, b[k]);
      else             tick(1, 0, '0, 1, 0, 8'h00);
      if (deliv < 0 && obs_in_q.size() != 0) deliv = k;
    end
    n_checks++; if (deliv < 0 || deliv > 5) $display("FAIL conc_recv_latency: got %0d want 1..5", deliv); else n_pass++;
    n_checks++;
    if (obs_in_q.size() != 1 || exp_in_q.size() == 0) begin
      $display("FAIL conc_recv: got %0d packets want 1", obs_in_q.size());
    end else begin
      got = obs_in_q.pop_front(); want = exp_in_q.pop_front();
      if (got !== want || got !== 32'h0102_0304) $display("FAIL conc_recv: got %h want %h", got, want);
      else n_pass++;
    end
    n_checks++; if (obs_out_q.size() !== 2) $display("FAIL conc_send_count: got %0d want 2", obs_out_q.size()); else n_pass++;
    while (obs_out_q.size() != 0 && exp_q.size() != 0) begin
      got = obs_out_q.pop_front(); want = exp_q.pop_front();
      n_checks++; if (got !== want) $display("FAIL conc_send_order: got %h want %h", got, want); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 1, 32'hA1A2_A3A4, 1, 0, 8'h00);
    tick(1, 1, 32'hB1B2_B3B4, 1, 1, 8'hC1);
    tick(1, 0, '0, 1, 1, 8'hC2);
    tick(0, 0, '0, 1, 1, 8'hC3);
    tick(1, 0, '0, 1, 0, 8'h00);
    n_checks++; if (put_outbound !== 1'b0) $display("FAIL midrst_put_outbound: got %b want 0", put_outbound); else n_pass++;
    n_checks++; if (payload_outbound !== 8'h00) $display("FAIL midrst_payload: got %h want 00", payload_outbound); else n_pass++;
    n_checks++; if (free_inbound !== 1'b1) $display("FAIL midrst_free_inbound: got %b want 1", free_inbound); else n_pass++;
    n_checks++; if (pkt_out !== 32'h0) $display("FAIL midrst_pkt_out: got %h want 00000000", pkt_out); else n_pass++;
    n_checks++; if (cQ_full !== 1'b0) $display("FAIL midrst_cq_full: got %b want 0", cQ_full); else n_pass++;
    repeat (15) tick(1, 0, '0, 1, 0, 8'h00);
    n_checks++; if (obs_out_q.size() !== 0) $display("FAIL midrst_queue_empty: got %0d packets want 0", obs_out_q.size()); else n_pass++;
    n_checks++; if (obs_in_q.size() !== 0) $display("FAIL midrst_no_partial: got %0d packets want 0", obs_in_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    int burst, gap, fo_pct;
    bit pi, fo;
    logic [31:0] got, want;
    burst = 0; gap = 0;
    for (int k = 0; k < 400; k++) begin
      fo_pct = (k < 200) ? 25 : 75;
      fo = ($urandom_range(0, 99) < fo_pct);
      pi = 1'b0;
      if (burst > 0) begin
        pi = 1'b1; burst--;
        if (burst == 0) gap = $urandom_range(1, 3);
      end else if (gap > 0) begin
        gap--;
      end else if ($urandom_range(0, 3) == 0) begin
        pi = 1'b1; burst = 3;
      end
      tick(1, bit'($urandom_range(0, 1)), $urandom, fo, pi, 8'($urandom));
    end
    repeat (60) tick(1, 0, '0, 1, 0, 8'h00);
    n_checks++; if (obs_out_q.size() !== exp_q.size()) $display("FAIL rand_send_count: got %0d want %0d", obs_out_q.size(), exp_q.size()); else n_pass++;
    while (obs_out_q.size() != 0 && exp_q.size() != 0) begin
      got = obs_out_q.pop_front(); want = exp_q.pop_front();
      n_checks++; if (got !== want) $display("FAIL rand_send_data: got %h want %h", got, want); else n_pass++;
    end
    n_checks++; if (obs_in_q.size() !== exp_in_q.size()) $display("FAIL rand_recv_count: got %0d want %0d", obs_in_q.size(), exp_in_q.size()); else n_pass++;
    while (obs_in_q.size() != 0 && exp_in_q.size() != 0) begin
      got = obs_in_q.pop_front(); want = exp_in_q.pop_front();
      n_checks++; if (got !== want) $display("FAIL rand_recv_data: got %h want %h", got, want); else n_pass++;
    end
  endtask

  task automatic test_monitors();
    n_checks++; if (full_err !== 0) $display("FAIL cq_full_timing: got %0d bad cycles want 0", full_err); else n_pass++;
    n_checks++; if (free_err !== 0) $display("FAIL free_inbound_timing: got %0d bad cycles want 0", free_err); else n_pass++;
    n_checks++; if (run_err !== 0) $display("FAIL put_outbound_runs: got %0d short runs want 0", run_err); else n_pass++;
    n_checks++; if (idle_err !== 0) $display("FAIL idle_payload: got %0d bad cycles want 0", idle_err); else n_pass++;
    n_checks++; if (hold_err !== 0) $display("FAIL pkt_out_hold: got %0d bad cycles want 0", hold_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_queue_full();
    test_drain();
    test_receive();
    test_concurrent();
    test_reset_mid();
    test_random();
    test_monitors();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
